// File: rtl/tiny_dnn_axil_master.sv
// tiny_dnn_axil_master: single-outstanding AXI4-Lite initiator bridging a valid/ready command
// port to the tiny_dnn slave register map, with a sticky stall watchdog on B/R waits.
module tiny_dnn_axil_master #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              timeout,
    output logic [31:0]       M_AXI_AWADDR,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [31:0]       M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [31:0]       M_AXI_ARADDR,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);
    typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RDATA, RSP} state_t;
    localparam logic [31:0] TO_LIM = 32'(TIMEOUT);
    state_t state, state_n;
    logic aw_v, aw_v_n, w_v, w_v_n, b_r, b_r_n, ar_v, ar_v_n, r_r, r_r_n;
    logic rv, rv_n, rw, rw_n, to_q, to_n, waiting;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [31:0] wdata, wdata_n, rdata, rdata_n, cnt, cnt_n;
    logic [1:0] resp, resp_n;
    assign waiting = state == WRESP || state == RDATA;
    always_comb begin
        state_n = state;
        aw_v_n  = aw_v;
        w_v_n   = w_v;
        b_r_n   = b_r;
        ar_v_n  = ar_v;
        r_r_n   = r_r;
        rv_n    = rv;
        rw_n    = rw;
        addr_n  = addr;
        wdata_n = wdata;
        rdata_n = rdata;
        resp_n  = resp;
        cnt_n   = waiting && cnt != TO_LIM ? cnt + 32'd1 : cnt;
        // the transaction keeps waiting after the flag sets; abandoning it is not legal AXI
        to_n    = waiting && TIMEOUT != 0 && cnt_n == TO_LIM ? 1'b1 : to_q;
        case (state)
            IDLE: if (cmd_valid) begin
                state_n = cmd_write ? WR : RD;
                addr_n  = cmd_addr & ~ADDR_W'(3);
                wdata_n = cmd_wdata;
                aw_v_n  = cmd_write;
                w_v_n   = cmd_write;
                ar_v_n  = !cmd_write;
                to_n    = 1'b0;
            end
            WR: begin
                aw_v_n = aw_v && !M_AXI_AWREADY;
                w_v_n  = w_v && !M_AXI_WREADY;
                if (!aw_v_n && !w_v_n) begin
                    state_n = WRESP;
                    b_r_n   = 1'b1;
                    cnt_n   = '0;
                end
            end
            WRESP: if (M_AXI_BVALID) begin
                state_n = RSP;
                b_r_n   = 1'b0;
                rv_n    = 1'b1;
                rw_n    = 1'b1;
                rdata_n = '0;
                resp_n  = M_AXI_BRESP;
            end
            RD: if (M_AXI_ARREADY) begin
                state_n = RDATA;
                ar_v_n  = 1'b0;
                r_r_n   = 1'b1;
                cnt_n   = '0;
            end
            RDATA: if (M_AXI_RVALID) begin
                state_n = RSP;
                r_r_n   = 1'b0;
                rv_n    = 1'b1;
                rw_n    = 1'b0;
                rdata_n = M_AXI_RDATA;
                resp_n  = M_AXI_RRESP;
            end
            RSP: if (rsp_ready) begin
                state_n = IDLE;
                rv_n    = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state <= IDLE;
            aw_v  <= 1'b0;
            w_v   <= 1'b0;
            b_r   <= 1'b0;
            ar_v  <= 1'b0;
            r_r   <= 1'b0;
            rv    <= 1'b0;
            rw    <= 1'b0;
            to_q  <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            rdata <= '0;
            resp  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            aw_v  <= aw_v_n;
            w_v   <= w_v_n;
            b_r   <= b_r_n;
            ar_v  <= ar_v_n;
            r_r   <= r_r_n;
            rv    <= rv_n;
            rw    <= rw_n;
            to_q  <= to_n;
            addr  <= addr_n;
            wdata <= wdata_n;
            rdata <= rdata_n;
            resp  <= resp_n;
            cnt   <= cnt_n;
        end
    end
    assign cmd_ready     = state == IDLE;
    assign rsp_valid     = rv;
    assign rsp_write     = rw;
    assign rsp_rdata     = rdata;
    assign rsp_resp      = resp;
    assign timeout       = to_q;
    assign M_AXI_AWADDR  = 32'(addr);
    assign M_AXI_AWVALID = aw_v;
    assign M_AXI_WDATA   = wdata;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = w_v;
    assign M_AXI_BREADY  = b_r;
    assign M_AXI_ARADDR  = 32'(addr);
    assign M_AXI_ARVALID = ar_v;
    assign M_AXI_RREADY  = r_r;
endmodule
